// File: rtl/sprite_pixel_output_if.sv
// Signal bundle between the PPU sequencer and the sprite pixel output unit.
// The master drives the load, step and mask controls; the slave returns the winning sprite pixel.
interface sprite_pixel_output_if;
  logic       clock_EN;
  logic       load_EN;
  logic [2:0] loadSlot;
  logic [1:0] loadSel;
  logic [7:0] loadData;
  logic       lineStart;
  logic       pixel_EN;
  logic       spritesEnable;
  logic       showLeftSprites;
  logic       sprite0InLine;
  logic       bgOpaque;
  logic       resetFlags;
  logic [1:0] spritePixel;
  logic [1:0] spritePalette;
  logic       spritePriority;
  logic       spriteZero;
  logic       spriteCollision;

  modport master (
    output clock_EN, load_EN, loadSlot, loadSel, loadData, lineStart, pixel_EN,
           spritesEnable, showLeftSprites, sprite0InLine, bgOpaque, resetFlags,
    input  spritePixel, spritePalette, spritePriority, spriteZero, spriteCollision
  );

  modport slave (
    input  clock_EN, load_EN, loadSlot, loadSel, loadData, lineStart, pixel_EN,
           spritesEnable, showLeftSprites, sprite0InLine, bgOpaque, resetFlags,
    output spritePixel, spritePalette, spritePriority, spriteZero, spriteCollision
  );
endinterface

// File: rtl/sprite_pixel_output.sv
// Eight-slot per-line sprite shifter with priority select and registered outputs.
// Define SPRITE_COLLISION_EN to build the sticky sprite-0 hit flag; otherwise it is tied low.
module sprite_pixel_output (
  input logic                  clock,
  input logic                  reset,
  sprite_pixel_output_if.slave sif
);

  logic [7:0] attr_q  [8];
  logic [7:0] attr_d  [8];
  logic [7:0] xcnt_q  [8];
  logic [7:0] xcnt_d  [8];
  logic [7:0] patlo_q [8];
  logic [7:0] patlo_d [8];
  logic [7:0] pathi_q [8];
  logic [7:0] pathi_d [8];
  logic [8:0] col_q, col_d;
  logic [1:0] pix_q, pix_d;
  logic [1:0] pal_q, pal_d;
  logic       pri_q, pri_d;
  logic       zero_q, zero_d;

  logic [8:0] col_eff;
  logic       step;
  logic       left_clip;
  logic       win_found;
  logic [2:0] win_idx;
  logic [1:0] contrib [8];

  // A lineStart in the same cycle as a step makes that step land on column 0.
  assign col_eff   = sif.lineStart ? 9'd0 : col_q;
  assign step      = sif.clock_EN && sif.pixel_EN && !col_eff[8];
  assign left_clip = !sif.showLeftSprites && (col_eff < 9'd8);

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      contrib[i] = (xcnt_q[i] == 8'd0) ? {pathi_q[i][7], patlo_q[i][7]} : 2'b00;
    end
    for (int i = 7; i >= 0; i--) begin
      if (contrib[i] != 2'b00) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    attr_d  = attr_q;
    xcnt_d  = xcnt_q;
    patlo_d = patlo_q;
    pathi_d = pathi_q;
    col_d   = col_q;
    pix_d   = pix_q;
    pal_d   = pal_q;
    pri_d   = pri_q;
    zero_d  = zero_q;

    if (sif.clock_EN) begin
      col_d = col_eff;
      if (sif.pixel_EN) begin
        pix_d  = 2'b00;
        pal_d  = 2'b00;
        pri_d  = 1'b0;
        zero_d = 1'b0;
        if (step) begin
          if (sif.spritesEnable && !left_clip && win_found) begin
            pix_d  = contrib[win_idx];
            pal_d  = attr_q[win_idx][1:0];
            pri_d  = attr_q[win_idx][5];
            zero_d = (win_idx == 3'd0) && sif.sprite0InLine;
          end
          for (int i = 0; i < 8; i++) begin
            if (xcnt_q[i] != 8'd0) begin
              xcnt_d[i] = xcnt_q[i] - 8'd1;
            end else begin
              patlo_d[i] = {patlo_q[i][6:0], 1'b0};
              pathi_d[i] = {pathi_q[i][6:0], 1'b0};
            end
          end
          col_d = col_eff + 9'd1;
        end
      end
      // Applied after the step so a coincident load overrides the shift or decrement.
      if (sif.load_EN) begin
        case (sif.loadSel)
          2'd0:    attr_d[sif.loadSlot]  = sif.loadData;
          2'd1:    xcnt_d[sif.loadSlot]  = sif.loadData;
          2'd2:    patlo_d[sif.loadSlot] = sif.loadData;
          default: pathi_d[sif.loadSlot] = sif.loadData;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        attr_q[i]  <= 8'd0;
        xcnt_q[i]  <= 8'd0;
        patlo_q[i] <= 8'd0;
        pathi_q[i] <= 8'd0;
      end
      col_q  <= 9'd0;
      pix_q  <= 2'b00;
      pal_q  <= 2'b00;
      pri_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      attr_q  <= attr_d;
      xcnt_q  <= xcnt_d;
      patlo_q <= patlo_d;
      pathi_q <= pathi_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      pal_q   <= pal_d;
      pri_q   <= pri_d;
      zero_q  <= zero_d;
    end
  end

  assign sif.spritePixel    = pix_q;
  assign sif.spritePalette  = pal_q;
  assign sif.spritePriority = pri_q;
  assign sif.spriteZero     = zero_q;

  // Attribute bits 7:6 and 4:2 are stored for completeness but only feed the fetch stage.
  logic unused_attr;
  always_comb begin
    unused_attr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      unused_attr = unused_attr ^ (^{attr_q[i][7:6], attr_q[i][4:2]});
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic coll_q, coll_d;
  logic coll_set;

  // Slot 0 counts even when a lower-priority rule hides it; column 255 never registers a hit.
  assign coll_set = step && sif.sprite0InLine && (contrib[0] != 2'b00) && sif.bgOpaque &&
                    sif.spritesEnable && (col_eff != 9'd255) && !left_clip;

  always_comb begin
    coll_d = coll_q;
    if (sif.clock_EN) begin
      if (sif.resetFlags) begin
        coll_d = 1'b0;
      end else if (coll_set) begin
        coll_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign sif.spriteCollision = coll_q;
`else
  logic unused_coll;
  assign unused_coll = sif.bgOpaque ^ sif.resetFlags;
  assign sif.spriteCollision = 1'b0;
`endif

endmodule
